// File: rtl/paws_clk_pkg.sv
// Shared clock/reset sequencing definitions: FSM state encodings, the order in
// which domain resets are released, and small helpers used by the sequencer.
package paws_clk_pkg;

    typedef enum logic [2:0] {
        S_PLLRST     = 3'd0,
        S_WAITLOCK   = 3'd1,
        S_REL_CACHE  = 3'd2,
        S_REL_DECODE = 3'd3,
        S_REL_GPU    = 3'd4,
        S_REL_CPU    = 3'd5,
        S_RUN        = 3'd6
    } seq_state_e;

    localparam int NUM_DOMAINS = 4;
    localparam int DOM_CACHE   = 0;
    localparam int DOM_DECODE  = 1;
    localparam int DOM_GPU     = 2;
    localparam int DOM_CPU     = 3;

    // Release order: cache first, cpu last, then the run state.
    function automatic seq_state_e next_stage(input seq_state_e s);
        case (s)
            S_REL_CACHE:  return S_REL_DECODE;
            S_REL_DECODE: return S_REL_GPU;
            S_REL_GPU:    return S_REL_CPU;
            default:      return S_RUN;
        endcase
    endfunction

    function automatic logic [NUM_DOMAINS-1:0] release_mask(input seq_state_e s);
        logic [NUM_DOMAINS-1:0] m;
        m = '0;
        case (s)
            S_REL_CACHE:  m[DOM_CACHE]  = 1'b1;
            S_REL_DECODE: m[DOM_DECODE] = 1'b1;
            S_REL_GPU:    m[DOM_GPU]    = 1'b1;
            S_REL_CPU:    m[DOM_CPU]    = 1'b1;
            default:      m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs, with a synchronous
// clear that flushes both stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = clr ? '0 : d;
        sync_d = clr ? '0 : meta_q;
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, qualifies lock, then releases domain resets in order.
// Runs from the PLL's reference clock so it keeps working while the PLL is down.
module pll_reset_sequencer
    import paws_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int STAGE_GAP          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       pll_rst,
    output logic       rst_cache,
    output logic       rst_decode,
    output logic       rst_gpu,
    output logic       rst_cpu,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retries,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                       LOCK_TIMEOUT, STAGE_GAP)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    seq_state_e             state_q, state_d, nxt_stage;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       stable_q, stable_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [7:0]             retries_q, retries_d;
    logic                   locked_s;
    logic                   sync_clr;

    // Lock seen while the PLL is held in reset is stale; flushing the
    // synchronizer then makes every qualification start from a clean pipe.
    assign sync_clr = reset | pll_rst_q;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(clock),
        .clr(sync_clr),
        .d  (locked),
        .q  (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        pll_rst_d   = pll_rst_q;
        dom_rst_d   = dom_rst_q;
        ready_d     = ready_q;
        lock_lost_d = lock_lost_q;
        retries_d   = retries_q;
        nxt_stage   = next_stage(state_q);
        case (state_q)
            S_PLLRST: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == PLL_RST_LAST) begin
                    state_d   = S_WAITLOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end
            end
            S_WAITLOCK: begin
                cnt_d    = cnt_q + CNT_ONE;
                stable_d = locked_s ? stable_q + CNT_ONE : '0;
                if (locked_s && stable_q == STABLE_LAST) begin
                    state_d   = S_REL_CACHE;
                    cnt_d     = '0;
                    stable_d  = '0;
                    dom_rst_d = dom_rst_q & ~release_mask(S_REL_CACHE);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_PLLRST;
                    cnt_d     = '0;
                    stable_d  = '0;
                    pll_rst_d = 1'b1;
                    retries_d = sat_inc8(retries_q);
                end
            end
            S_REL_CACHE, S_REL_DECODE, S_REL_GPU, S_REL_CPU, S_RUN: begin
                // Lock loss outranks any pending stage advance.
                if (!locked_s) begin
                    state_d     = S_PLLRST;
                    cnt_d       = '0;
                    pll_rst_d   = 1'b1;
                    dom_rst_d   = '1;
                    ready_d     = 1'b0;
                    lock_lost_d = 1'b1;
                end else if (state_q != S_RUN) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == GAP_LAST) begin
                        state_d   = nxt_stage;
                        cnt_d     = '0;
                        dom_rst_d = dom_rst_q & ~release_mask(nxt_stage);
                        ready_d   = (nxt_stage == S_RUN);
                    end
                end
            end
            default: begin
                state_d   = S_PLLRST;
                cnt_d     = '0;
                stable_d  = '0;
                pll_rst_d = 1'b1;
                dom_rst_d = '1;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            stable_q    <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            retries_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_q   <= dom_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            retries_q   <= retries_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign rst_cache  = dom_rst_q[DOM_CACHE];
    assign rst_decode = dom_rst_q[DOM_DECODE];
    assign rst_gpu    = dom_rst_q[DOM_GPU];
    assign rst_cpu    = dom_rst_q[DOM_CPU];
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign retries    = retries_q;
    assign state      = state_q;

endmodule
